// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-requester arbiter.
// Holds the requester count, index width and FSM state encoding.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int HOLD_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] id2oh(input logic [ID_W-1:0] id);
        id2oh     = '0;
        id2oh[id] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Combinational winner picker: fixed priority (highest index wins)
// or round-robin search starting at a given index with wrap-around.
module rr_prio_select
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic               mode,
    input  logic [ID_W-1:0]    start,
    output logic [ID_W-1:0]    win_id,
    output logic               win_valid
);

    logic [NUM_REQ-1:0] eff;

    assign eff       = req & ~mask;
    assign win_valid = |eff;

    // Pick the winner; later loop iterations override earlier ones.
    always_comb begin
        logic [ID_W-1:0] idx;
        idx    = '0;
        win_id = '0;
        if (mode) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (eff[i]) win_id = ID_W'(i);
            end
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = start + ID_W'(k);
                if (eff[idx]) win_id = idx;
            end
        end
    end

endmodule

// File: rtl/arbiter_4req_rr.sv
// Four-requester arbiter with round-robin / fixed-priority policy,
// per-ownership hold limit and registered one-hot grant outputs.
module arbiter_4req_rr
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               mode,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               preempt
);

    localparam logic [HOLD_W-1:0] MAX_C = HOLD_W'(MAX_HOLD);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               preempt_q, preempt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;

    logic               own_req;
    logic               at_max;
    logic               force_rel;
    logic               arb_en;
    logic [NUM_REQ-1:0] mask;
    logic [ID_W-1:0]    start;
    logic [ID_W-1:0]    win_id;
    logic               win_valid;

    assign own_req   = req[gnt_id_q];
    assign at_max    = (hold_cnt_q >= MAX_C);
    assign force_rel = (state_q == GRANT) && own_req && at_max;
    assign mask      = force_rel ? id2oh(gnt_id_q) : '0;
    assign start     = last_id_q + ID_W'(1);

    // Arbitration runs only in IDLE or at a release point.
    assign arb_en = (state_q == IDLE) || !own_req || at_max;

    rr_prio_select u_sel (
        .req       (req),
        .mask      (mask),
        .mode      (mode),
        .start     (start),
        .win_id    (win_id),
        .win_valid (win_valid)
    );

    // Next state: hold the owner, hand over, or fall back to IDLE.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        preempt_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_id_d   = last_id_q;
        if (arb_en) begin
            preempt_d = force_rel;
            if (win_valid) begin
                state_d     = GRANT;
                gnt_d       = id2oh(win_id);
                gnt_id_d    = win_id;
                gnt_valid_d = 1'b1;
                hold_cnt_d  = HOLD_W'(1);
                last_id_d   = win_id;
            end else begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
            end
        end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
    end

    // State and output registers; reset drops any grant at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            hold_cnt_q  <= '0;
            last_id_q   <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
            hold_cnt_q  <= hold_cnt_d;
            last_id_q   <= last_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_arbiter_4req_rr.sv
// Directed bench for arbiter_4req_rr: two instances share stimulus,
// one with the default hold limit and one with MAX_HOLD=2.
module tb_arbiter_4req_rr;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       mode;

    logic [3:0] g8, g2;
    logic [1:0] id8, id2;
    logic       v8, v2;
    logic       p8, p2;

    int checks = 0;
    int errors = 0;

    arbiter_4req_rr #(.MAX_HOLD(8)) u8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mode      (mode),
        .gnt       (g8),
        .gnt_id    (id8),
        .gnt_valid (v8),
        .preempt   (p8)
    );

    arbiter_4req_rr #(.MAX_HOLD(2)) u2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mode      (mode),
        .gnt       (g2),
        .gnt_id    (id2),
        .gnt_valid (v2),
        .preempt   (p2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset mid-cycle; returns 4 time units after an edge.
    task automatic do_reset();
        tick();
        req   = 4'b0000;
        mode  = 1'b0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_g [9];
    logic       exp_p [9];

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        mode  = 1'b0;
        exp_g = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                  4'b0100, 4'b1000, 4'b1000, 4'b0001};
        exp_p = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                  1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        #12;
        chk("rst_gnt",     32'(g8),            32'h0);
        chk("rst_id",      32'(id8),           32'h0);
        chk("rst_valid",   32'(v8),            32'h0);
        chk("rst_preempt", 32'(p8),            32'h0);
        chk("rst_hold",    32'(u8.hold_cnt_q), 32'h0);
        chk("rst_last",    32'(u8.last_id_q),  32'h3);
        rst_n = 1'b1;

        // Basic one-cycle grant and release to idle
        req = 4'b0001;
        tick();
        chk("basic_gnt",   32'(g8),  32'h1);
        chk("basic_id",    32'(id8), 32'h0);
        chk("basic_valid", 32'(v8),  32'h1);
        chk("basic_last",  32'(u8.last_id_q), 32'h0);
        req = 4'b0000;
        tick();
        chk("basic_idle",  32'(g8), 32'h0);
        chk("basic_inv",   32'(v8), 32'h0);

        // Fixed priority, owner 3 forced out after 8 cycles
        do_reset();
        mode = 1'b1;
        req  = 4'b1111;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("fix_hold%0d", i), 32'(g8), 32'h8);
            chk($sformatf("fix_np%0d", i),   32'(p8), 32'h0);
        end
        chk("fix_hcnt", 32'(u8.hold_cnt_q), 32'h8);
        tick();
        chk("fix_next",    32'(g8),  32'h4);
        chk("fix_next_id", 32'(id8), 32'h2);
        chk("fix_preempt", 32'(p8),  32'h1);
        tick();
        chk("fix_pulse_end", 32'(p8), 32'h0);
        chk("fix_stay",      32'(g8), 32'h4);

        // Round-robin rotation with MAX_HOLD=2
        do_reset();
        mode = 1'b0;
        req  = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("rr_gnt%0d", i), 32'(g2), 32'(exp_g[i]));
            chk($sformatf("rr_pre%0d", i), 32'(p2), 32'(exp_p[i]));
        end

        // Owner drop hands over, non-owner and mode ignored mid-hold
        do_reset();
        req = 4'b0010;
        tick();
        chk("own1", 32'(g8), 32'h2);
        req = 4'b0110;
        tick();
        chk("own1_keep", 32'(g8), 32'h2);
        req = 4'b0100;
        tick();
        chk("own2",      32'(g8),            32'h4);
        chk("own2_last", 32'(u8.last_id_q),  32'h2);
        chk("own2_np",   32'(p8),            32'h0);
        mode = 1'b1;
        req  = 4'b1100;
        tick();
        chk("mode_mid", 32'(g8), 32'h4);
        req = 4'b1000;
        tick();
        chk("own3", 32'(g8), 32'h8);

        // Lone requester past the limit: one idle cycle, re-grant
        do_reset();
        req = 4'b0100;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("lone%0d", i), 32'(g8), 32'h4);
        end
        tick();
        chk("lone_gap",     32'(g8), 32'h0);
        chk("lone_gap_v",   32'(v8), 32'h0);
        chk("lone_gap_pre", 32'(p8), 32'h1);
        tick();
        chk("lone_regnt",   32'(g8),            32'h4);
        chk("lone_hcnt",    32'(u8.hold_cnt_q), 32'h1);
        chk("lone_np",      32'(p8),            32'h0);

        // Asynchronous reset in the middle of an ownership
        do_reset();
        req = 4'b1000;
        tick();
        chk("ar_pre", 32'(g8), 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_drop",   32'(g8), 32'h0);
        chk("ar_drop_v", 32'(v8), 32'h0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("ar_wait", 32'(g8), 32'h0);
        tick();
        chk("ar_regnt", 32'(g8),  32'h8);
        chk("ar_id",    32'(id8), 32'h3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
